alux_seq: RTL and testbench
===========================

# alux_seq

Command sequencer that drives the ALUX complex-arithmetic unit from the requesting side. It buffers operation requests in a small command FIFO, issues them one at a time over the ALUX start/done handshake, and captures each `outAB` result into a single-entry response register with valid/ready flow control. It sits between the system controller and one ALUX instance and owns all of that instance's input ports.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, at least 2.
- `TIMEOUT`, 64: maximum number of ISSUE cycles to wait for `alu_done`; used only when the timeout feature is compiled in.

- `clock`: in, 1. Master clock; all logic is posedge.
- `reset`: in, 1. Asynchronous, active-high reset.
- `cmd_valid`: in, 1. Command request.
- `cmd_ready`: out, 1. Equals `!full`, taken from the registered FIFO count.
- `cmd_opr`: in, 4. ALUX operation code.
- `cmd_a`: in, 64. Operand A; real part in [63:32], imaginary part in [31:0].
- `cmd_b`: in, 64. Operand B; same packing as `cmd_a`.
- `rsp_valid`: out, 1. Response available.
- `rsp_ready`: in, 1. Response consumed.
- `rsp_data`: out, 64. Captured `alu_outAB`.
- `rsp_opr`: out, 4. Operation code of the command that produced this response.
- `rsp_err`: out, 1. Response was generated by a timeout.
- `alu_inA`, `alu_inB`: out, 64 each. Registered operands driven to ALUX.
- `alu_opr`: out, 4. Registered operation code driven to ALUX.
- `alu_start`: out, 1. Registered start request to ALUX.
- `alu_done`: in, 1. ALUX completion flag.
- `alu_outAB`: in, 64. ALUX result.
- `busy`: out, 1. High when the state is not IDLE or the FIFO is non-empty.

## Operation
- **Reset:** every output is 0, except `cmd_ready`, which is 1. The FIFO is emptied and the state is IDLE.
- **Push:** occurs when `cmd_valid && cmd_ready`. The FIFO stores {opr, A, B}. Pointers wrap modulo `DEPTH`, and a count register of width log2(DEPTH)+1 tracks occupancy.
- **IDLE:** if the FIFO is non-empty and `rsp_valid` is 0, pop the head entry, load `alu_inA`, `alu_inB` and `alu_opr`, set `alu_start` to 1, and go to ISSUE.
- **ISSUE:**
  - `alu_start` stays at 1 and all operands are held stable.
  - On a cycle where `alu_done` is 1: set `alu_start` to 0 and go to CAPTURE.
- **CAPTURE:**
  - Register `rsp_data` from `alu_outAB`, `rsp_opr` from `alu_opr`, and `rsp_err` as 0.
  - Set `rsp_valid` to 1 and go to RESP.
  - This stage exists because ALUX updates `outAB` on the edge after the one that raised `done`.
- **RESP:** hold all `rsp_*` signals stable while `rsp_ready` is 0. When `rsp_valid && rsp_ready`, clear `rsp_valid` and return to IDLE.
- **Push during a pop:** a push and a pop in the same cycle are both legal, and the count is unchanged. When the FIFO is full, the `cmd_ready` seen in that cycle is still 0, so the simultaneous push is not accepted.
- **Empty FIFO:** remain in IDLE with `alu_start` at 0.
- **Operation codes:** `cmd_opr` values are not checked; undefined codes are passed through to ALUX.
- **Reset mid-operation:** asserting `reset` in any state forces `alu_start` to 0 immediately (asynchronously). Any in-flight command and all queued commands are discarded, and no response is produced for them.

## Timing
- Command accepted at edge E0 into an empty FIFO:
  - E1: IDLE pops the entry; `alu_start` is 1 after E1.
  - E2: ALUX raises `done`.
  - E3: ALUX updates `outAB`; the sequencer drops `alu_start`.
  - E4: CAPTURE runs; `rsp_valid` is 1 after E4.
- Minimum command-to-response latency is therefore 4 cycles.
- Back-to-back throughput is one command per 5 cycles while `rsp_ready` is held at 1.
- `alu_start` is never high while a response is still pending.

## Configuration
- Macro: `ALUX_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter is cleared on entry to ISSUE and increments on every ISSUE cycle.
  - When the counter reaches `TIMEOUT` and `alu_done` is still 0, set `alu_start` to 0, go directly to RESP, and produce a response with `rsp_data` = 0, `rsp_err` = 1 and `rsp_opr` = the issued opcode.
  - If `alu_done` is 1 on that same cycle, `done` wins and the normal path is taken.
- **Undefined:**
  - No counter is built; ISSUE waits for `alu_done` indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
1. **Addition:** send opr 0010 with A = {32'd3, 32'd4} and B = {32'd1, 32'd2} to an ALUX model. Required: `rsp_data` = {32'd4, 32'd6}, `rsp_opr` = 0010, `rsp_err` = 0, and `rsp_valid` first high 4 cycles after acceptance.
2. **Backpressure:** push 5 commands with `DEPTH` = 4 and `rsp_ready` held at 0. Required: `cmd_ready` drops to 0 after the FIFO fills. The first response is held stable until `rsp_ready` goes to 1, then all 5 responses arrive in order: 0000 returns A, 0001 returns B, 0011 returns A−B, 1000 with A=B returns 64'd1, and 1111 returns 0.
3. **Response stall:** hold `rsp_ready` at 0 for 10 cycles with 2 commands queued. Required: `alu_start` stays at 0 throughout and the FIFO count stays at 1.
4. **Timeout:** build with `ALUX_SEQ_TIMEOUT_EN` and `TIMEOUT` = 8, with `alu_done` tied to 0. Required: `alu_start` is high for 8 cycles, followed by `rsp_err` = 1 and `rsp_data` = 0. Without the macro, the sequencer must remain in ISSUE for 100 cycles or more.
5. **Reset during ISSUE:** assert `reset` mid-cycle while the sequencer is in ISSUE with 2 commands queued. Required: `alu_start` goes to 0 before the next edge, and `busy`, `rsp_valid` and the count are all 0.
6. **Done on the timeout cycle:** with the timeout feature enabled, assert `alu_done` on the same cycle the counter reaches `TIMEOUT`. Required: a normal response with `rsp_err` = 0.

Source files
------------

// File: rtl/alux_seq_if.sv
// alux_seq_if: command/response bus between the system controller (master)
// and the alux_seq command sequencer (slave).
interface alux_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opr;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_opr;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_opr, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_opr, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_opr, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_opr, rsp_err
    );
endinterface

// File: rtl/alux_seq.sv
// alux_seq: command FIFO, start/done issue FSM and response register for one ALUX.
// Define ALUX_SEQ_TIMEOUT_EN to build the ISSUE-state timeout (TIMEOUT cycles).
module alux_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    alux_seq_if.slave   bus,
    output logic [63:0] alu_inA,
    output logic [63:0] alu_inB,
    output logic [3:0]  alu_opr,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [63:0] alu_outAB,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("alux_seq: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef struct packed {
        logic [3:0]  opr;
        logic [63:0] a;
        logic [63:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t         state;
    cmd_t           mem [DEPTH];
    cmd_t           cmd_in;
    cmd_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           rsp_valid_q;
    logic [63:0]    rsp_data_q;
    logic [3:0]     rsp_opr_q;

`ifdef ALUX_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  timer;
    logic           rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign cmd_in        = {bus.cmd_opr, bus.cmd_a, bus.cmd_b};
    assign head          = mem[rd_ptr];
    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // A new command is only launched once the previous response has been taken.
    assign pop           = (state == S_IDLE) && (count != '0) && !rsp_valid_q;
    assign busy          = (state != S_IDLE) || (count != '0);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_opr   = rsp_opr_q;

    // NOTE: FIFO storage has no reset; occupancy is defined by the pointers and count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            alu_inA     <= '0;
            alu_inB     <= '0;
            alu_opr     <= '0;
            alu_start   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_opr_q   <= '0;
`ifdef ALUX_SEQ_TIMEOUT_EN
            timer       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_inA   <= head.a;
                        alu_inB   <= head.b;
                        alu_opr   <= head.opr;
                        alu_start <= 1'b1;
                        state     <= S_ISSUE;
`ifdef ALUX_SEQ_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
                end

                S_ISSUE: begin
                    // done takes priority over an expiring timeout on the same cycle
                    if (alu_done) begin
                        alu_start <= 1'b0;
                        state     <= S_CAPTURE;
                    end
`ifdef ALUX_SEQ_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT - 1)) begin
                        alu_start   <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_opr_q   <= alu_opr;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
`endif
                end

                S_CAPTURE: begin
                    // ALUX updates outAB one edge after done, so it is sampled here.
                    rsp_data_q  <= alu_outAB;
                    rsp_opr_q   <= alu_opr;
                    rsp_valid_q <= 1'b1;
`ifdef ALUX_SEQ_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state       <= S_RESP;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alux_seq.sv
// tb_alux_seq: directed, table-driven bench for alux_seq with a small ALUX responder.
// Timeout sequences are compiled in when ALUX_SEQ_TIMEOUT_EN is defined.
module tb_alux_seq;
    logic        clock;
    logic        reset;
    logic [63:0] alu_inA;
    logic [63:0] alu_inB;
    logic [3:0]  alu_opr;
    logic        alu_start;
    logic        alu_done;
    logic [63:0] alu_outAB;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    alux_seq_if bus ();

    alux_seq #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_opr   (alu_opr),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_outAB (alu_outAB),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALUX stand-in: done one edge after start, outAB one edge after done.
    logic        model_en;
    logic        done_force;
    logic        m_done;
    logic        m_fired;
    logic [63:0] m_res;

    function automatic logic [63:0] alux_ref(input logic [3:0] o, input logic [63:0] a,
                                             input logic [63:0] b);
        case (o)
            4'b0000: return a;
            4'b0001: return b;
            4'b0010: return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
            4'b0011: return {a[63:32] - b[63:32], a[31:0] - b[31:0]};
            4'b1000: return (a == b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_done    <= 1'b0;
            m_fired   <= 1'b0;
            m_res     <= '0;
            alu_outAB <= '0;
        end else begin
            if (model_en && alu_start && !m_done && !m_fired) begin
                m_done  <= 1'b1;
                m_fired <= 1'b1;
                m_res   <= alux_ref(alu_opr, alu_inA, alu_inB);
            end else if (m_done) begin
                m_done    <= 1'b0;
                alu_outAB <= m_res;
            end
            if (!alu_start) begin
                m_fired <= 1'b0;
            end
        end
    end

    assign alu_done = m_done | done_force;

    typedef struct {
        logic [3:0]  opr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [8];
    vec_t bp   [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push_cmd(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_opr   = o;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int hi;
        int bad_cnt;
        int guard;

        vecs[0] = '{4'b0010, {32'd3, 32'd4}, {32'd1, 32'd2}, {32'd4, 32'd6}};
        vecs[1] = '{4'b0000, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h1234_5678_9ABC_DEF0};
        vecs[2] = '{4'b0001, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h0FED_CBA9_8765_4321};
        vecs[3] = '{4'b0011, {32'd10, 32'd5}, {32'd3, 32'd7}, {32'd7, 32'hFFFF_FFFE}};
        vecs[4] = '{4'b1000, 64'hAAAA_5555_0F0F_F0F0, 64'hAAAA_5555_0F0F_F0F0, 64'd1};
        vecs[5] = '{4'b1000, 64'hAAAA_5555_0F0F_F0F0, 64'hAAAA_5555_0F0F_F0F1, 64'd0};
        vecs[6] = '{4'b0111, 64'h1, 64'h2, 64'd0};
        vecs[7] = '{4'b0010, {32'hFFFF_FFFF, 32'd1}, {32'd1, 32'd1}, {32'd0, 32'd2}};

        bp[0] = '{4'b0000, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001};
        bp[1] = '{4'b0001, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888};
        bp[2] = '{4'b0011, {32'd100, 32'd50}, {32'd40, 32'd20}, {32'd60, 32'd30}};
        bp[3] = '{4'b1000, 64'hCAFE_F00D_CAFE_F00D, 64'hCAFE_F00D_CAFE_F00D, 64'd1};
        bp[4] = '{4'b1111, 64'd1, 64'd2, 64'd0};

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_opr   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        model_en      = 1'b1;
        done_force    = 1'b0;

        repeat (2) @(negedge clock);
        check("reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset rsp_data", bus.rsp_data, 64'd0);
        check("reset rsp_opr", 64'(bus.rsp_opr), 64'd0);
        check("reset rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset alu_start", 64'(alu_start), 64'd0);
        check("reset alu_inA", alu_inA, 64'd0);
        check("reset alu_inB", alu_inB, 64'd0);
        check("reset alu_opr", 64'(alu_opr), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single commands from idle: result, opcode echo, error flag, latency.
        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].opr, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d rsp_data", i), bus.rsp_data, vecs[i].exp);
            check($sformatf("vec%0d rsp_opr", i), 64'(bus.rsp_opr), 64'(vecs[i].opr));
            check($sformatf("vec%0d rsp_err", i), 64'(bus.rsp_err), 64'd0);
            consume();
            check($sformatf("vec%0d rsp_valid cleared", i), 64'(bus.rsp_valid), 64'd0);
        end

        // Backpressure: five commands into a four-deep FIFO with rsp_ready low.
        for (int i = 0; i < 5; i++) begin
            push_cmd(bp[i].opr, bp[i].a, bp[i].b);
        end
        check("bp cmd_ready full", 64'(bus.cmd_ready), 64'd0);
        check("bp count full", 64'(dut.count), 64'd4);
        bus.cmd_valid = 1'b1;
        bus.cmd_opr   = 4'b0000;
        bus.cmd_a     = 64'hBAD;
        bus.cmd_b     = 64'hBAD;
        repeat (2) @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("bp push while full", 64'(dut.count), 64'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp held rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp held rsp_data", bus.rsp_data, bp[0].exp);
        end
        for (int i = 0; i < 5; i++) begin
            wait_rsp(lat);
            check($sformatf("bp%0d rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("bp%0d rsp_data", i), bus.rsp_data, bp[i].exp);
            check($sformatf("bp%0d rsp_opr", i), 64'(bus.rsp_opr), 64'(bp[i].opr));
            consume();
        end
        check("bp drained busy", 64'(busy), 64'd0);

        // Response stall with a second command queued.
        push_cmd(4'b0010, {32'd1, 32'd1}, {32'd2, 32'd2});
        push_cmd(4'b0000, 64'h77, 64'h0);
        wait_rsp(lat);
        hi      = 0;
        bad_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (alu_start) hi++;
            if (dut.count != 3'd1) bad_cnt++;
        end
        check("stall alu_start cycles", 64'(hi), 64'd0);
        check("stall count!=1 cycles", 64'(bad_cnt), 64'd0);
        check("stall rsp_data held", bus.rsp_data, {32'd3, 32'd3});
        consume();
        wait_rsp(lat);
        check("stall second rsp_data", bus.rsp_data, 64'h77);
        consume();

`ifdef ALUX_SEQ_TIMEOUT_EN
        // Timeout with done stuck low: start high 8 cycles, then an error response.
        model_en = 1'b0;
        push_cmd(4'b0101, 64'h1, 64'h2);
        hi  = 0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
            if (alu_start) hi++;
        end
        check("timeout start cycles", 64'(hi), 64'd8);
        check("timeout rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("timeout rsp_err", 64'(bus.rsp_err), 64'd1);
        check("timeout rsp_data", bus.rsp_data, 64'd0);
        check("timeout rsp_opr", 64'(bus.rsp_opr), 64'd5);
        consume();

        // done arriving on the same cycle the timeout would fire.
        push_cmd(4'b0110, 64'h3, 64'h4);
        hi    = 0;
        guard = 0;
        while (hi < 8 && guard < 40) begin
            @(negedge clock);
            guard++;
            if (alu_start) hi++;
        end
        done_force = 1'b1;
        @(negedge clock);
        done_force = 1'b0;
        wait_rsp(lat);
        check("done-wins rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("done-wins rsp_err", 64'(bus.rsp_err), 64'd0);
        check("done-wins rsp_opr", 64'(bus.rsp_opr), 64'd6);
        consume();
`endif

        // Reset during ISSUE with two commands queued.
        model_en = 1'b0;
        push_cmd(4'b0010, 64'h10, 64'h20);
        push_cmd(4'b0000, 64'h30, 64'h40);
        push_cmd(4'b0001, 64'h50, 64'h60);
`ifndef ALUX_SEQ_TIMEOUT_EN
        hi = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clock);
            if (alu_start && !bus.rsp_valid) hi++;
        end
        check("no-timeout issue cycles", 64'(hi), 64'd110);
`endif
        check("pre-reset alu_start", 64'(alu_start), 64'd1);
        check("pre-reset count", 64'(dut.count), 64'd2);
        #1 reset = 1'b1;
        #1;
        check("mid-reset alu_start", 64'(alu_start), 64'd0);
        check("mid-reset busy", 64'(busy), 64'd0);
        check("mid-reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid-reset count", 64'(dut.count), 64'd0);
        check("mid-reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clock);
        #1 reset = 1'b0;
        model_en = 1'b1;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (alu_start || bus.rsp_valid) hi++;
        end
        check("post-reset no activity", 64'(hi), 64'd0);

        push_cmd(vecs[0].opr, vecs[0].a, vecs[0].b);
        wait_rsp(lat);
        check("post-reset latency", 64'(lat), 64'd4);
        check("post-reset rsp_data", bus.rsp_data, vecs[0].exp);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
